// File: rtl/maj33_voter.sv
// ---------------------------------------------------------------------------
// maj33_voter
//   33-input majority voter. The population count of the 33 scalar inputs is
//   formed combinationally by a full-adder compression tree. It is compared
//   against THRESHOLD, and the result is registered once. This gives exactly
//   one clock of latency, and a new vector can be applied every cycle.
//
// Parameters
//   THRESHOLD  minimum number of ones for y0=1 (legal 1..33, default 17)
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   x0..x32    voter inputs; x0 is bit 0 of the conceptual vector x[32:0]
//   hw_q       [5:0] registered popcount (only with MAJ33_COUNT_OUT_EN)
//   y0         registered majority result
//
// Optional feature
//   `define MAJ33_COUNT_OUT_EN adds the hw_q output port. hw_q is updated on
//   the same edge as y0 and resets to 0. y0 behaves identically either way.
// ---------------------------------------------------------------------------
module maj33_voter #(
  parameter int THRESHOLD = 17
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       x0,
  input  logic       x1,
  input  logic       x2,
  input  logic       x3,
  input  logic       x4,
  input  logic       x5,
  input  logic       x6,
  input  logic       x7,
  input  logic       x8,
  input  logic       x9,
  input  logic       x10,
  input  logic       x11,
  input  logic       x12,
  input  logic       x13,
  input  logic       x14,
  input  logic       x15,
  input  logic       x16,
  input  logic       x17,
  input  logic       x18,
  input  logic       x19,
  input  logic       x20,
  input  logic       x21,
  input  logic       x22,
  input  logic       x23,
  input  logic       x24,
  input  logic       x25,
  input  logic       x26,
  input  logic       x27,
  input  logic       x28,
  input  logic       x29,
  input  logic       x30,
  input  logic       x31,
  input  logic       x32,
`ifdef MAJ33_COUNT_OUT_EN
  output logic [5:0] hw_q,
`endif
  output logic       y0
);

  localparam logic [5:0] THR = 6'(THRESHOLD);

  logic [32:0] x_vec;
  logic [1:0]  s1 [11];   // full-adder outputs, 0..3 each
  logic [2:0]  s2 [5];    // pair sums, 0..6 each
  logic [3:0]  s3 [3];    // 0..12 (third one 0..9)
  logic [4:0]  s4;        // 0..24
  logic [5:0]  hw_d;      // 0..33, no overflow possible in 6 bits
  logic        y0_d;
  logic        y0_q;

  assign x_vec = {x32, x31, x30, x29, x28, x27, x26, x25, x24, x23, x22,
                  x21, x20, x19, x18, x17, x16, x15, x14, x13, x12, x11,
                  x10, x9,  x8,  x7,  x6,  x5,  x4,  x3,  x2,  x1,  x0};

  // Compression tree: 33 bits -> 11 full adders -> balanced adder tree.
  // s1[10] is the odd one out and joins the tree at the third level.
  always_comb begin
    for (int i = 0; i < 11; i++) begin
      s1[i][0] = x_vec[3*i] ^ x_vec[3*i+1] ^ x_vec[3*i+2];
      s1[i][1] = (x_vec[3*i]   & x_vec[3*i+1]) |
                 (x_vec[3*i]   & x_vec[3*i+2]) |
                 (x_vec[3*i+1] & x_vec[3*i+2]);
    end
    for (int i = 0; i < 5; i++) begin
      s2[i] = {1'b0, s1[2*i]} + {1'b0, s1[2*i+1]};
    end
    s3[0] = {1'b0, s2[0]} + {1'b0, s2[1]};
    s3[1] = {1'b0, s2[2]} + {1'b0, s2[3]};
    s3[2] = {1'b0, s2[4]} + {2'b00, s1[10]};
    s4    = {1'b0, s3[0]} + {1'b0, s3[1]};
    hw_d  = {1'b0, s4} + {2'b00, s3[2]};
    y0_d  = (hw_d >= THR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y0_q <= 1'b0;
    end else begin
      y0_q <= y0_d;
    end
  end

  assign y0 = y0_q;

`ifdef MAJ33_COUNT_OUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hw_q <= 6'd0;
    end else begin
      hw_q <= hw_d;
    end
  end
`endif

endmodule

// File: tb/tb_maj33_voter.sv
// Scoreboard bench for maj33_voter. The driver applies one vector per cycle
// on the falling edge and pushes the expected response. The monitor pops and
// compares one entry just after every rising edge.
module tb_maj33_voter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [32:0] x   = '0;
  logic        y0;
`ifdef MAJ33_COUNT_OUT_EN
  logic [5:0]  hw_q;
`endif

  int checks = 0;
  int errors = 0;
  bit drv_done = 1'b0;

  typedef struct packed {
    logic       y;
    logic [5:0] hw;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  maj33_voter #(.THRESHOLD(17)) dut (
    .clk (clk),
    .rst (rst),
    .x0  (x[0]),  .x1  (x[1]),  .x2  (x[2]),  .x3  (x[3]),
    .x4  (x[4]),  .x5  (x[5]),  .x6  (x[6]),  .x7  (x[7]),
    .x8  (x[8]),  .x9  (x[9]),  .x10 (x[10]), .x11 (x[11]),
    .x12 (x[12]), .x13 (x[13]), .x14 (x[14]), .x15 (x[15]),
    .x16 (x[16]), .x17 (x[17]), .x18 (x[18]), .x19 (x[19]),
    .x20 (x[20]), .x21 (x[21]), .x22 (x[22]), .x23 (x[23]),
    .x24 (x[24]), .x25 (x[25]), .x26 (x[26]), .x27 (x[27]),
    .x28 (x[28]), .x29 (x[29]), .x30 (x[30]), .x31 (x[31]),
    .x32 (x[32]),
`ifdef MAJ33_COUNT_OUT_EN
    .hw_q(hw_q),
`endif
    .y0  (y0)
  );

  // Apply one vector for the next rising edge and record what must appear.
  task automatic apply(input logic [32:0] v, input logic r,
                       input logic exp_y, input logic [5:0] exp_hw);
    exp_t e;
    @(negedge clk);
    x   = v;
    rst = r;
    e.y  = exp_y;
    e.hw = exp_hw;
    exp_q.push_back(e);
  endtask

  // Monitor: every edge consumes exactly one expectation, so a latency
  // error or a bubble shows up as a value mismatch.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (y0 !== e.y) begin
          errors++;
          $display("FAIL y0 at %0t: got %b expected %b", $time, y0, e.y);
        end
`ifdef MAJ33_COUNT_OUT_EN
        checks++;
        if (hw_q !== e.hw) begin
          errors++;
          $display("FAIL hw_q at %0t: got %0d expected %0d", $time, hw_q, e.hw);
        end
`endif
      end
    end
  end

  initial begin
    logic [32:0] v;
    logic [32:0] hw16_v;
    logic [32:0] hw17_v;
    logic [32:0] hw20_v;
    int          wait_cycles;

    hw16_v = 33'h0_0000_FFFF;
    hw17_v = 33'h0_0001_FFFF;
    hw20_v = 33'h0_000F_FFFF;

    // Reset with all inputs high, then release.
    apply({33{1'b1}}, 1'b1, 1'b0, 6'd0);
    apply({33{1'b1}}, 1'b1, 1'b0, 6'd0);
    apply({33{1'b1}}, 1'b0, 1'b1, 6'd33);

    // Extremes.
    apply(33'h0_0000_0000, 1'b0, 1'b0, 6'd0);
    apply(33'h1_FFFF_FFFF, 1'b0, 1'b1, 6'd33);

    // Threshold edge and symmetry.
    apply(hw16_v,          1'b0, 1'b0, 6'd16);
    apply(hw17_v,          1'b0, 1'b1, 6'd17);
    apply(33'h1_FFFF_0000, 1'b0, 1'b1, 6'd17);
    apply(33'h1_5555_5555, 1'b0, 1'b1, 6'd17);
    apply(33'h0_AAAA_AAAA, 1'b0, 1'b0, 6'd16);
    apply(33'h0_0000_0001, 1'b0, 1'b0, 6'd1);
    apply(33'h1_FFFF_FFFE, 1'b0, 1'b1, 6'd32);

    // Back-to-back alternation, no bubbles.
    for (int i = 0; i < 6; i++) begin
      apply(hw16_v, 1'b0, 1'b0, 6'd16);
      apply(hw17_v, 1'b0, 1'b1, 6'd17);
    end

    // Mid-stream reset while streaming hw=20.
    apply(hw20_v, 1'b0, 1'b1, 6'd20);
    apply(hw20_v, 1'b0, 1'b1, 6'd20);
    apply(hw20_v, 1'b1, 1'b0, 6'd0);
    apply(hw20_v, 1'b0, 1'b1, 6'd20);
    apply(hw20_v, 1'b0, 1'b1, 6'd20);

    // Random vectors against an independent popcount reference.
    for (int i = 0; i < 2000; i++) begin
      v = {1'($urandom), 32'($urandom)};
      apply(v, 1'b0, ($countones(v) >= 17), 6'($countones(v)));
    end

    drv_done = 1'b1;
    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 10) begin
      @(posedge clk);
      wait_cycles++;
    end
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
